// File: rtl/round_sched_pkg.sv
// Shared definitions for the round-robin rounding scheduler: rounding-mode
// encodings, the output-register FSM states and the per-mode increment rule.
package round_defs;

  typedef logic [2:0] round_mode_t;

  localparam round_mode_t IEEE_NEAR = 3'd0;
  localparam round_mode_t IEEE_ZERO = 3'd1;
  localparam round_mode_t IEEE_PINF = 3'd2;
  localparam round_mode_t IEEE_NINF = 3'd3;
  localparam round_mode_t NEAR_UP   = 3'd4;
  localparam round_mode_t AWAY_ZERO = 3'd5;

  localparam int STAT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sched_state_t;

  // Unlisted codes fall back to round-to-nearest-even.
  function automatic logic round_inc(input round_mode_t mode, input logic sign,
                                     input logic guard, input logic sticky,
                                     input logic lsb);
    logic inc;
    case (mode)
      IEEE_ZERO: inc = 1'b0;
      IEEE_PINF: inc = !sign && (guard || sticky);
      IEEE_NINF: inc = sign && (guard || sticky);
      NEAR_UP:   inc = guard;
      AWAY_ZERO: inc = guard || sticky;
      default:   inc = guard && (sticky || lsb);
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/round_sched_rr.sv
// Round-robin picker: first asserted valid at or after rr_ptr_i, wrapping to 0.
// The grant is qualified by can_accept_i; the winner index is always computed.
module round_sched_rr #(
  parameter  int N_REQ = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  rr_ptr_i,
  input  logic             can_accept_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  winner_o,
  output logic             grant_vld_o
);

  always_comb begin : pick
    logic found;
    int   idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    found       = 1'b0;
    idx         = 0;
    winner_o    = '0;
    grant_o     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && valid_i[idx]) begin
        found    = 1'b1;
        winner_o = ID_W'(idx);
      end
    end
    grant_vld_o = found && can_accept_i;
    if (grant_vld_o) grant_o[winner_o] = 1'b1;
  end

endmodule

// File: rtl/round_sched.sv
// Shared mantissa rounder with round-robin arbitration and a one-entry output
// register. Optional grant/inexact statistics are enabled by ROUND_SCHED_STATS_EN.
module round_sched
  import round_defs::*;
#(
  parameter  int N_REQ  = 2,
  parameter  int MANT_W = 24,
  parameter  int EXP_W  = 10,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*MANT_W-1:0] req_mant,
  input  logic [N_REQ*EXP_W-1:0]  req_exp,
  input  logic [N_REQ-1:0]        req_guard,
  input  logic [N_REQ-1:0]        req_sticky,
  input  logic [N_REQ-1:0]        req_sign,
  input  logic [N_REQ*3-1:0]      req_round,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_W-1:0]         out_id,
  output logic [MANT_W-1:0]       out_mant,
  output logic [EXP_W-1:0]        out_exp,
`ifdef ROUND_SCHED_STATS_EN
  output logic [N_REQ*STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0]       stat_inexact,
`endif
  output logic                    out_inexact
);

  sched_state_t      state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [MANT_W-1:0] out_mant_q, out_mant_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic              out_inexact_q, out_inexact_d;

  logic              can_accept;
  logic              grant_vld;
  logic [ID_W-1:0]   winner;
  logic [N_REQ-1:0]  grant;

  // Accepting while FULL is allowed when the consumer drains in the same cycle.
  assign can_accept = !rst && ((state_q == EMPTY) || out_ready);

  round_sched_rr #(.N_REQ(N_REQ)) u_rr (
    .valid_i     (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .can_accept_i(can_accept),
    .grant_o     (grant),
    .winner_o    (winner),
    .grant_vld_o (grant_vld)
  );

  assign req_ready = grant;

  logic [MANT_W-1:0] sel_mant;
  logic [EXP_W-1:0]  sel_exp;
  logic              sel_guard, sel_sticky, sel_sign;
  round_mode_t       sel_round;
  logic              inc;
  logic [MANT_W:0]   sum;
  logic [MANT_W-1:0] rnd_mant;
  logic [EXP_W-1:0]  rnd_exp;

  assign sel_mant   = req_mant[int'(winner)*MANT_W +: MANT_W];
  assign sel_exp    = req_exp[int'(winner)*EXP_W +: EXP_W];
  assign sel_round  = req_round[int'(winner)*3 +: 3];
  assign sel_guard  = req_guard[winner];
  assign sel_sticky = req_sticky[winner];
  assign sel_sign   = req_sign[winner];

  assign inc      = round_inc(sel_round, sel_sign, sel_guard, sel_sticky, sel_mant[0]);
  assign sum      = {1'b0, sel_mant} + (MANT_W+1)'(inc);
  // A carry-out can only come from an all-ones mantissa, so sum>>1 is 100..0.
  assign rnd_mant = sum[MANT_W] ? sum[MANT_W:1] : sum[MANT_W-1:0];
  assign rnd_exp  = sel_exp + EXP_W'(sum[MANT_W]);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    out_id_d      = out_id_q;
    out_mant_d    = out_mant_q;
    out_exp_d     = out_exp_q;
    out_inexact_d = out_inexact_q;
    case (state_q)
      EMPTY:   if (grant_vld) state_d = FULL;
      FULL:    if (out_ready && !grant_vld) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (grant_vld) begin
      rr_ptr_d      = (winner == ID_W'(N_REQ-1)) ? '0 : winner + ID_W'(1);
      out_id_d      = winner;
      out_mant_d    = rnd_mant;
      out_exp_d     = rnd_exp;
      out_inexact_d = sel_guard | sel_sticky;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      rr_ptr_q      <= '0;
      out_id_q      <= '0;
      out_mant_q    <= '0;
      out_exp_q     <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      out_id_q      <= out_id_d;
      out_mant_q    <= out_mant_d;
      out_exp_q     <= out_exp_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_valid   = (state_q == FULL);
  assign out_id      = out_id_q;
  assign out_mant    = out_mant_q;
  assign out_exp     = out_exp_q;
  assign out_inexact = out_inexact_q;

`ifdef ROUND_SCHED_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [N_REQ-1:0][STAT_W-1:0] grant_cnt_q;
  logic [STAT_W-1:0]            inexact_cnt_q;

  // Inexact results are counted when the consumer takes them, not at grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q   <= '0;
      inexact_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && grant_cnt_q[i] != STAT_MAX)
          grant_cnt_q[i] <= grant_cnt_q[i] + STAT_W'(1);
      end
      if (out_valid && out_ready && out_inexact_q && inexact_cnt_q != STAT_MAX)
        inexact_cnt_q <= inexact_cnt_q + STAT_W'(1);
    end
  end

  assign stat_grants  = grant_cnt_q;
  assign stat_inexact = inexact_cnt_q;
`endif

endmodule

// File: tb/tb_round_sched.sv
// Scoreboard bench for round_sched: the driver pushes hand-computed results on
// each expected grant, the monitor pops and compares on every output handshake.
module tb_round_sched;
  import round_defs::*;

  localparam int N_REQ  = 2;
  localparam int MANT_W = 24;
  localparam int EXP_W  = 10;

  typedef struct packed {
    logic [0:0]        id;
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic              inexact;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*MANT_W-1:0] req_mant;
  logic [N_REQ*EXP_W-1:0]  req_exp;
  logic [N_REQ-1:0]        req_guard, req_sticky, req_sign;
  logic [N_REQ*3-1:0]      req_round;
  logic                    out_valid, out_ready;
  logic [0:0]              out_id;
  logic [MANT_W-1:0]       out_mant;
  logic [EXP_W-1:0]        out_exp;
  logic                    out_inexact;
`ifdef ROUND_SCHED_STATS_EN
  logic [N_REQ*16-1:0]     stat_grants;
  logic [15:0]             stat_inexact;
`endif

  round_sched #(.N_REQ(N_REQ), .MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mant   (req_mant),
    .req_exp    (req_exp),
    .req_guard  (req_guard),
    .req_sticky (req_sticky),
    .req_sign   (req_sign),
    .req_round  (req_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_mant   (out_mant),
    .out_exp    (out_exp),
`ifdef ROUND_SCHED_STATS_EN
    .stat_grants (stat_grants),
    .stat_inexact(stat_inexact),
`endif
    .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [MANT_W-1:0] m,
                              input logic [EXP_W-1:0] e, input logic inx);
    exp_t r;
    r.id      = id[0:0];
    r.mant    = m;
    r.exp     = e;
    r.inexact = inx;
    return r;
  endfunction

  task automatic set_req(input int i, input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e,
                         input logic g, input logic s, input logic sg, input round_mode_t md);
    req_mant[i*MANT_W +: MANT_W] = m;
    req_exp[i*EXP_W +: EXP_W]    = e;
    req_guard[i]                 = g;
    req_sticky[i]                = s;
    req_sign[i]                  = sg;
    req_round[i*3 +: 3]          = md;
  endtask

  // One cycle of stimulus, entered and left #1 after a rising edge.
  task automatic step(input logic [N_REQ-1:0] vld, input logic ordy,
                      input logic [N_REQ-1:0] exp_rdy, input exp_t e);
    req_valid = vld;
    out_ready = ordy;
    @(negedge clk);
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (exp_rdy != '0) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got id %0d mant 0x%0h, expected no result", out_id, out_mant);
      end else begin
        e = sb.pop_front();
        check("out_id",      64'(out_id),      64'(e.id));
        check("out_mant",    64'(out_mant),    64'(e.mant));
        check("out_exp",     64'(out_exp),     64'(e.exp));
        check("out_inexact", 64'(out_inexact), 64'(e.inexact));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    out_ready = 1'b1;
    req_mant = '0; req_exp = '0; req_guard = '0; req_sticky = '0; req_sign = '0; req_round = '0;
    set_req(0, 24'h800000, 10'd10, 1'b0, 1'b0, 1'b0, IEEE_NEAR);
    set_req(1, 24'hC00001, 10'd20, 1'b1, 1'b0, 1'b0, IEEE_NEAR);

    // Reset with every requester asking: nothing may be granted.
    repeat (2) begin
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
    end
    check("rst_out_id",      64'(out_id),      64'd0);
    check("rst_out_mant",    64'(out_mant),    64'd0);
    check("rst_out_exp",     64'(out_exp),     64'd0);
    check("rst_out_inexact", 64'(out_inexact), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Alternating grants, starting with requester 0.
    step(2'b11, 1'b1, 2'b01, mk(0, 24'h800000, 10'd10, 1'b0));
    step(2'b11, 1'b1, 2'b10, mk(1, 24'hC00002, 10'd20, 1'b1));
    step(2'b11, 1'b1, 2'b01, mk(0, 24'h800000, 10'd10, 1'b0));
    step(2'b11, 1'b1, 2'b10, mk(1, 24'hC00002, 10'd20, 1'b1));

    // Mantissa carry-out renormalises and bumps the exponent.
    set_req(0, 24'hFFFFFF, 10'd127, 1'b1, 1'b0, 1'b0, IEEE_NEAR);
    step(2'b01, 1'b1, 2'b01, mk(0, 24'h800000, 10'd128, 1'b1));

    // Directed modes on a negative, sticky-only value.
    set_req(1, 24'h800001, 10'd50, 1'b0, 1'b1, 1'b1, IEEE_PINF);
    step(2'b10, 1'b1, 2'b10, mk(1, 24'h800001, 10'd50, 1'b1));
    set_req(1, 24'h800001, 10'd50, 1'b0, 1'b1, 1'b1, IEEE_NINF);
    step(2'b10, 1'b1, 2'b10, mk(1, 24'h800002, 10'd50, 1'b1));
    set_req(1, 24'h800001, 10'd50, 1'b0, 1'b1, 1'b1, IEEE_ZERO);
    step(2'b10, 1'b1, 2'b10, mk(1, 24'h800001, 10'd50, 1'b1));

    // Remaining modes, tie-to-even, unlisted code and exponent wrap.
    set_req(0, 24'h000010, 10'd5, 1'b1, 1'b0, 1'b0, NEAR_UP);
    step(2'b01, 1'b1, 2'b01, mk(0, 24'h000011, 10'd5, 1'b1));
    set_req(0, 24'h000010, 10'd5, 1'b0, 1'b1, 1'b0, AWAY_ZERO);
    step(2'b01, 1'b1, 2'b01, mk(0, 24'h000011, 10'd5, 1'b1));
    set_req(0, 24'h000010, 10'd5, 1'b1, 1'b0, 1'b0, IEEE_NEAR);
    step(2'b01, 1'b1, 2'b01, mk(0, 24'h000010, 10'd5, 1'b1));
    set_req(0, 24'h000011, 10'd5, 1'b1, 1'b0, 1'b0, 3'd7);
    step(2'b01, 1'b1, 2'b01, mk(0, 24'h000012, 10'd5, 1'b1));
    set_req(0, 24'hFFFFFF, 10'h3FF, 1'b1, 1'b1, 1'b0, AWAY_ZERO);
    step(2'b01, 1'b1, 2'b01, mk(0, 24'h800000, 10'd0, 1'b1));
    step(2'b00, 1'b1, 2'b00, '0);

    // Backpressure: held result frozen, then drain and accept together.
    set_req(1, 24'h123456, 10'd33, 1'b0, 1'b0, 1'b0, IEEE_NEAR);
    step(2'b10, 1'b0, 2'b10, mk(1, 24'h123456, 10'd33, 1'b0));
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 1'b0, 2'b00, '0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_mant",  64'(out_mant),  64'h123456);
      check("bp_out_exp",   64'(out_exp),   64'd33);
    end
    set_req(1, 24'h123457, 10'd34, 1'b1, 1'b0, 1'b0, IEEE_NEAR);
    step(2'b10, 1'b1, 2'b10, mk(1, 24'h123458, 10'd34, 1'b1));
    step(2'b00, 1'b1, 2'b00, '0);
    check("drained_out_valid", 64'(out_valid), 64'd0);

    // Reset while a result is held drops it.
    set_req(0, 24'h800000, 10'd1, 1'b0, 1'b0, 1'b0, IEEE_NEAR);
    set_req(1, 24'h400000, 10'd2, 1'b0, 1'b0, 1'b0, IEEE_NEAR);
    step(2'b01, 1'b0, 2'b01, mk(0, 24'h800000, 10'd1, 1'b0));
    rst       = 1'b1;
    req_valid = 2'b11;
    out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Five grants to requester 0, three to 1, the last two inexact.
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 1'b1, 2'b01, mk(0, 24'h800000, 10'd1, 1'b0));
      step(2'b11, 1'b1, 2'b10, mk(1, 24'h400000, 10'd2, 1'b0));
    end
    set_req(0, 24'h800001, 10'd1, 1'b1, 1'b0, 1'b0, IEEE_NEAR);
    step(2'b01, 1'b1, 2'b01, mk(0, 24'h800002, 10'd1, 1'b1));
    step(2'b01, 1'b1, 2'b01, mk(0, 24'h800002, 10'd1, 1'b1));
    step(2'b00, 1'b1, 2'b00, '0);
`ifdef ROUND_SCHED_STATS_EN
    check("stat_grants",  64'(stat_grants),  64'({16'd3, 16'd5}));
    check("stat_inexact", 64'(stat_inexact), 64'd2);
`endif

    step(2'b00, 1'b1, 2'b00, '0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
